// File: rtl/lc3b_pipe_reg.sv
// lc3b_pipe_reg: generic LC-3b pipeline stage register with a two-entry skid buffer.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   flush                  synchronous kill of every held beat (inserts a bubble)
//   in_valid / in_ready    upstream handshake; in_ready depends on state only
//   in_data / in_ctrl      upstream payload and control word
//   out_valid / out_ready  downstream handshake
//   out_data / out_ctrl    payload and control word, forced to zero when no beat is held
//   count                  number of beats held (0, 1, 2)
module lc3b_pipe_reg #(
    parameter int unsigned DATA_W = 70,
    parameter int unsigned CTRL_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    // The state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] main_data, main_data_next;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_next;
    logic [DATA_W-1:0] skid_data, skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_next;
    logic              accept;
    logic              take;

    // Handshake flags come straight from the state register.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign count     = state;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // Outputs present the main entry; bubbles are masked to all-zero.
    assign out_data = out_valid ? main_data : '0;
    assign out_ctrl = out_valid ? main_ctrl : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_next;
            main_data <= main_data_next;
            main_ctrl <= main_ctrl_next;
            skid_data <= skid_data_next;
            skid_ctrl <= skid_ctrl_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_data_next = main_data;
        main_ctrl_next = main_ctrl;
        skid_data_next = skid_data;
        skid_ctrl_next = skid_ctrl;

        if (flush) begin
            // Flush wins over everything: drop held beats and anything moving this cycle.
            state_next     = EMPTY;
            main_data_next = '0;
            main_ctrl_next = '0;
            skid_data_next = '0;
            skid_ctrl_next = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next     = ONE;
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end else if (accept) begin
                        state_next     = FULL;
                        skid_data_next = in_data;
                        skid_ctrl_next = in_ctrl;
                    end else if (take) begin
                        state_next     = EMPTY;
                        main_data_next = '0;
                        main_ctrl_next = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a take can move the state.
                    if (take) begin
                        state_next     = ONE;
                        main_data_next = skid_data;
                        main_ctrl_next = skid_ctrl;
                        skid_data_next = '0;
                        skid_ctrl_next = '0;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_data_next = '0;
                    main_ctrl_next = '0;
                    skid_data_next = '0;
                    skid_ctrl_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_pipe_reg.sv
// tb_lc3b_pipe_reg: self-checking bench for lc3b_pipe_reg using a reference queue.
module tb_lc3b_pipe_reg;

    localparam int unsigned DATA_W = 70;
    localparam int unsigned CTRL_W = 32;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        count;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } beat_t;

    beat_t sb[$];
    int    checks;
    int    errors;

    lc3b_pipe_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_outputs(input string tag);
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic [CTRL_W-1:0] exp_ctrl;
        exp_valid = (sb.size() != 0);
        exp_data  = exp_valid ? sb[0].d : '0;
        exp_ctrl  = exp_valid ? sb[0].c : '0;
        check_eq({tag, ".count"},     count,     sb.size());
        check_eq({tag, ".out_valid"}, out_valid, exp_valid);
        check_eq({tag, ".in_ready"},  in_ready,  sb.size() < 2);
        check_eq({tag, ".out_ctrl"},  out_ctrl,  exp_ctrl);
        check_eq({tag, ".out_data"},  out_data,  exp_data);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge.
    task automatic drive_cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                               input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
        logic  acc;
        logic  tk;
        beat_t b;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        // in_ready must not follow out_ready or in_valid within the cycle.
        in_valid  = ~v;
        out_ready = ~ordy;
        #1;
        check_eq({tag, ".in_ready_comb"}, in_ready, sb.size() < 2);
        in_valid  = v;
        out_ready = ordy;
        acc = v && (sb.size() < 2);
        tk  = (sb.size() != 0) && ordy;
        if (fl) begin
            sb.delete();
        end else begin
            if (tk) void'(sb.pop_front());
            if (acc) begin
                b.d = d;
                b.c = c;
                sb.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs("reset");

        // Streaming with out_ready high
        drive_cycle("stream1", 1'b1, 70'h11, 32'h1, 1'b1, 1'b0);
        drive_cycle("stream2", 1'b1, 70'h22, 32'h2, 1'b1, 1'b0);
        drive_cycle("stream3", 1'b1, 70'h33, 32'h3, 1'b1, 1'b0);
        drive_cycle("stream4", 1'b0, 70'h0,  32'h0, 1'b1, 1'b0);

        // Back-pressure: C held until accepted, then drained in order
        drive_cycle("bp1", 1'b1, 70'hA0, 32'hA, 1'b1, 1'b0);
        drive_cycle("bp2", 1'b1, 70'hB0, 32'hB, 1'b0, 1'b0);
        drive_cycle("bp3", 1'b1, 70'hC0, 32'hC, 1'b0, 1'b0);
        check_eq("bp_full_ctrl", out_ctrl, 32'hA);
        drive_cycle("bp4", 1'b1, 70'hC0, 32'hC, 1'b1, 1'b0);
        drive_cycle("bp5", 1'b1, 70'hC0, 32'hC, 1'b1, 1'b0);
        drive_cycle("bp6", 1'b0, 70'h0,  32'h0, 1'b1, 1'b0);
        drive_cycle("bp7", 1'b0, 70'h0,  32'h0, 1'b1, 1'b0);

        // Flush while full with a beat on the input
        drive_cycle("fl1", 1'b1, 70'h50, 32'h5, 1'b0, 1'b0);
        drive_cycle("fl2", 1'b1, 70'h60, 32'h6, 1'b0, 1'b0);
        drive_cycle("fl3", 1'b1, 70'h70, 32'h7, 1'b0, 1'b1);
        check_eq("flush_count", count, 2'd0);
        drive_cycle("fl4", 1'b0, 70'h0, 32'h0, 1'b1, 1'b0);

        // Bubble masking after a single beat
        drive_cycle("bub1", 1'b1, 70'h1234, 32'h9, 1'b1, 1'b0);
        drive_cycle("bub2", 1'b0, 70'h0,    32'h0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges while full
        drive_cycle("ar1", 1'b1, 70'hD0, 32'hD, 1'b0, 1'b0);
        drive_cycle("ar2", 1'b1, 70'hE0, 32'hE, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check_eq("async.count",     count,     2'd0);
        check_eq("async.out_valid", out_valid, 1'b0);
        check_eq("async.out_ctrl",  out_ctrl,  32'h0);
        check_eq("async.out_data",  out_data,  70'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_cycle("ar3", 1'b1, 70'hF0, 32'hF, 1'b1, 1'b0);
        drive_cycle("ar4", 1'b0, 70'h0,  32'h0, 1'b1, 1'b0);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            rd = {$urandom(), $urandom(), $urandom()};
            drive_cycle("rand", $urandom_range(0, 3) != 0, rd, $urandom(),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
